hough_frame_sink: RTL and testbench

Output-side consumer for the lane-detection pipeline. Drains the 8-bit processed-pixel FIFO at the tail of the image pipeline, packs four pixels per 32-bit word, and writes one full frame into a word-addressed frame-buffer BRAM for host readback. It is the reading end of the pipeline's output FIFO handshake. It signals frame completion and keeps a wrapping frame counter.

---
 rtl/hough_frame_sink.sv | 143 ++++++++++++++
 tb/tb_hough_frame_sink.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hough_frame_sink.sv
// Frame sink: drains the pixel FIFO, packs 4 pixels/word into the frame-buffer BRAM, counts frames.
// Optional HOUGH_SINK_CHECKSUM_EN adds a 16-bit pixel-sum output. Pops only when FIFO non-empty.
module hough_frame_sink #(
    parameter int WIDTH          = 512,
    parameter int HEIGHT         = 288,
    parameter int WORD_ADDR_BITS = $clog2(WIDTH*HEIGHT/4)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      in_empty_i,
    input  logic [7:0]                in_dout_i,
    output logic                      in_rd_en_o,
    output logic                      bram_wr_en_o,
    output logic [WORD_ADDR_BITS-1:0] bram_wr_addr_o,
    output logic [31:0]               bram_wr_data_o,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic [7:0]                frame_count_o
`ifdef HOUGH_SINK_CHECKSUM_EN
    ,
    output logic [15:0]               frame_checksum_o
`endif
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             pix_cnt_q, pix_cnt_d;
    logic [1:0]                lane_q, lane_d;
    logic [31:0]               pack_q, pack_d;
    logic [WORD_ADDR_BITS-1:0] word_cnt_q, word_cnt_d;
    logic                      wr_en_q, wr_en_d;
    logic [WORD_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]               wr_data_q, wr_data_d;
    logic [7:0]                fc_q, fc_d;
    logic                      pop;

    assign pop = (state_q == S_RUN) && !in_empty_i;

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        lane_d     = lane_q;
        pack_d     = pack_q;
        word_cnt_d = word_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        fc_d       = fc_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_RUN;
                    pix_cnt_d  = '0;
                    lane_d     = '0;
                    word_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (pop) begin
                    pack_d[{lane_q, 3'b000} +: 8] = in_dout_i;
                    lane_d    = lane_q + 2'd1;
                    pix_cnt_d = pix_cnt_q + CW'(1);
                    // Fourth lane completes the word; it is written out on the following cycle.
                    if (lane_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = pack_d;
                        wr_addr_d  = word_cnt_q;
                        word_cnt_d = word_cnt_q + WORD_ADDR_BITS'(1);
                    end
                    if (pix_cnt_q == CW'(NPIX - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                fc_d    = fc_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pix_cnt_q  <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            word_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            fc_q       <= '0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            word_cnt_q <= word_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            fc_q       <= fc_d;
        end
    end

`ifdef HOUGH_SINK_CHECKSUM_EN
    logic [15:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (state_q == S_IDLE && start_i) begin
            cks_d = '0;
        end else if (pop) begin
            cks_d = cks_q + {8'd0, in_dout_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign frame_checksum_o = cks_q;
`endif

    assign in_rd_en_o     = pop;
    assign bram_wr_en_o   = wr_en_q;
    assign bram_wr_addr_o = wr_addr_q;
    assign bram_wr_data_o = wr_data_q;
    assign busy_o         = (state_q != S_IDLE);
    assign frame_done_o   = (state_q == S_DONE);
    assign frame_count_o  = fc_q;

endmodule

// File: tb/tb_hough_frame_sink.sv
// Bench for hough_frame_sink at 8x2 pixels: FIFO model, write scoreboard, directed frames.
module tb_hough_frame_sink;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int AB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_empty = 1'b1;
    logic [7:0]    in_dout = 8'h00;
    logic          in_rd_en;
    logic          bram_wr_en;
    logic [AB-1:0] bram_wr_addr;
    logic [31:0]   bram_wr_data;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_count;
`ifdef HOUGH_SINK_CHECKSUM_EN
    logic [15:0]   frame_checksum;
`endif

    hough_frame_sink #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .in_empty_i     (in_empty),
        .in_dout_i      (in_dout),
        .in_rd_en_o     (in_rd_en),
        .bram_wr_en_o   (bram_wr_en),
        .bram_wr_addr_o (bram_wr_addr),
        .bram_wr_data_o (bram_wr_data),
        .busy_o         (busy),
        .frame_done_o   (frame_done),
        .frame_count_o  (frame_count)
`ifdef HOUGH_SINK_CHECKSUM_EN
        ,
        .frame_checksum_o (frame_checksum)
`endif
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          pops = 0;
    int          rd_viol = 0;
    int          rate = 1;
    int          feed_tick = 0;
    logic [7:0]  exp_fc = 8'd0;
    logic [7:0]  fifo [$];
    logic [7:0]  src [$];
    logic [33:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: pop decided from values seen at the edge, contents updated just after it.
    always @(posedge clk) begin
        bit do_pop;
        do_pop = in_rd_en;
        if (do_pop && in_empty) rd_viol++;
        #1;
        if (do_pop && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        feed_tick++;
        if (src.size() > 0 && feed_tick >= rate) begin
            fifo.push_back(src.pop_front());
            feed_tick = 0;
        end
        in_empty = (fifo.size() == 0);
        in_dout  = in_empty ? 8'h00 : fifo[0];
    end

    always @(negedge clk) begin
        if (rst_n && bram_wr_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write", bram_wr_addr, bram_wr_data);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({bram_wr_addr, bram_wr_data} !== e) begin
                    miscompares++;
                    $display("FAIL write: got addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                             bram_wr_addr, bram_wr_data, e[33:32], e[31:0]);
                end
            end
        end
    end

    // mode: 0 = incrementing from base, 1 = all pixels equal base
    task automatic do_frame(input logic [7:0] base, input bit same, input int r,
                            input int idle_wait, input bit restart, input bit chk_lat);
        logic [7:0]  px [16];
        logic [15:0] sum;
        int          cnt;
        int          p0;
        bit          seen;
        sum = 16'd0;
        for (int i = 0; i < 16; i++) begin
            px[i] = same ? base : base + 8'(i);
            sum   = sum + {8'd0, px[i]};
        end
        for (int w = 0; w < 4; w++)
            exp_q.push_back({2'(w), px[4*w+3], px[4*w+2], px[4*w+1], px[4*w]});
        if (r == 0) begin
            for (int i = 0; i < 16; i++) fifo.push_back(px[i]);
        end else begin
            rate = r;
            feed_tick = 0;
            for (int i = 0; i < 16; i++) src.push_back(px[i]);
        end
        p0 = pops;
        repeat (idle_wait) @(posedge clk);
        if (idle_wait > 0) chk("idle_no_pop", pops - p0, 0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // cnt: edges from the start launch edge through the edge closing the frame_done cycle
        cnt  = 1;
        seen = 1'b0;
        while (!seen && cnt < 300) begin
            @(negedge clk);
            if (restart && cnt == 5) start = 1'b1;
            if (restart && cnt == 6) start = 1'b0;
            if (frame_done) seen = 1'b1;
            else begin
                @(posedge clk);
                cnt++;
            end
        end
        cnt++;
        chk("frame_done_seen", 32'(seen), 32'd1);
        if (chk_lat) chk("frame_done_latency", cnt, 18);
        exp_fc = exp_fc + 8'd1;
        @(negedge clk);
        chk("frame_done_single_pulse", 32'(frame_done), 32'd0);
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
        chk("writes_outstanding", exp_q.size(), 0);
        chk("busy_after_frame", 32'(busy), 32'd0);
`ifdef HOUGH_SINK_CHECKSUM_EN
        chk("frame_checksum", 32'(frame_checksum), 32'(sum));
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(in_rd_en), 32'd0);
        chk({tag, "_wr_en"}, 32'(bram_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bram_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, bram_wr_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
`ifdef HOUGH_SINK_CHECKSUM_EN
        chk({tag, "_checksum"}, 32'(frame_checksum), 32'd0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int guard;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // continuous frame, FIFO preloaded
        do_frame(8'h00, 1'b0, 0, 0, 1'b0, 1'b1);
        // starved: one pixel every 3 cycles
        do_frame(8'h20, 1'b0, 3, 0, 1'b0, 1'b0);
        // early data held in IDLE, second start during RUN ignored
        do_frame(8'h40, 1'b0, 0, 6, 1'b1, 1'b0);

        // reset after 6 pops: only word 0 reaches the BRAM
        exp_q.push_back({2'd0, 32'h03020100});
        for (int i = 0; i < 16; i++) fifo.push_back(8'(i));
        p0 = pops;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (pops - p0 < 6 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reset_pops_reached", pops - p0, 6);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        chk("midreset_writes", exp_q.size(), 0);
        fifo.delete();
        src.delete();
        exp_fc = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_count", 32'(frame_count), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        do_frame(8'hA0, 1'b0, 0, 0, 1'b0, 1'b0);

        // all-0xFF frame (checksum 0x0FF0 when enabled)
        do_frame(8'hFF, 1'b1, 0, 0, 1'b0, 1'b0);

        // 256 more frames: frame_count wraps through 255 -> 0
        for (int f = 0; f < 256; f++) do_frame(8'(f), 1'b0, 0, 0, 1'b0, 1'b0);

        chk("rd_en_while_empty", rd_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
